// File: rtl/serial_slice_adder_if.sv
// serial_slice_adder_if: operand/handshake/result bundle for the slice-serial adder
interface serial_slice_adder_if #(parameter int WIDTH = 16);
  logic start, sub, carry_in, busy, done, carry_out, overflow, zero;
  logic [WIDTH-1:0] a_in, b_in, sum_out;
  modport master(output start, sub, a_in, b_in, carry_in,
                 input busy, done, sum_out, carry_out, overflow, zero);
  modport slave(input start, sub, a_in, b_in, carry_in,
                output busy, done, sum_out, carry_out, overflow, zero);
endinterface

// File: rtl/serial_slice_adder.sv
// serial_slice_adder: WIDTH-bit add/sub computed SLICE bits per clock, LSB first
module serial_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic clk,
  input logic reset,
  serial_slice_adder_if.slave bus
);
  localparam int N = WIDTH / SLICE;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, sum_nx;
  logic [SLICE-1:0] a_s, b_s, s;
  logic [KW-1:0] k;
  logic carry_r, c_o, c_msb, last;
  assign bus.busy = state == RUN;
  always_comb begin
    a_s = a_r[k*SLICE +: SLICE];
    b_s = b_r[k*SLICE +: SLICE];
    {c_o, s} = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_r};
    // sum bit = a ^ b ^ cin, so the carry into the top bit falls out of it
    c_msb = a_s[SLICE-1] ^ b_s[SLICE-1] ^ s[SLICE-1];
    sum_nx = bus.sum_out;
    sum_nx[k*SLICE +: SLICE] = s;
    last = k == KW'(N - 1);
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      k <= '0;
      carry_r <= 1'b0;
      bus.done <= 1'b0;
      bus.sum_out <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      state <= state_nx;
      bus.done <= 1'b0;
      if (state == IDLE && bus.start) begin
        a_r <= bus.a_in;
        b_r <= bus.sub ? ~bus.b_in : bus.b_in;
        carry_r <= bus.sub | bus.carry_in;
        k <= '0;
        bus.sum_out <= '0;
        bus.carry_out <= 1'b0;
        bus.overflow <= 1'b0;
        bus.zero <= 1'b0;
      end else if (state == RUN) begin
        bus.sum_out <= sum_nx;
        carry_r <= c_o;
        k <= last ? '0 : k + KW'(1);
        if (last) begin
          bus.carry_out <= c_o;
          bus.overflow <= c_msb ^ c_o;
          bus.zero <= sum_nx == '0;
          bus.done <= 1'b1;
        end
      end
    end
  end
endmodule
